// File: rtl/midi_byte_parser.sv
// MIDI byte-stream parser: tracks running status, numbers each byte within its message,
// tracks sysex framing, forwards realtime bytes and counts discarded bytes.
module midi_byte_parser #(
   parameter int RT_PASS = 1
) (
   input  logic       data_clk,
   input  logic       reset_reg_N,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       byteready,
   output logic [7:0] cur_status,
   output logic [7:0] midibyte_nr,
   output logic [7:0] midi_in_data,
   output logic       sysex_active,
   output logic       rt_strobe,
   output logic [7:0] rt_data,
   output logic [7:0] drop_cnt
);

   typedef enum logic [1:0] {IDLE, CHAN, SYSEX, SYX_END} state_t;

   state_t     state;
   logic [1:0] exp_len;
   logic       armed;
   logic       take;
   logic       is_rt;
   logic       is_chan_status;
   logic       is_data;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? 8'hFF : v + 8'd1;
   endfunction

   // armed stays low for the first edge after reset release so a byte landing on that edge is ignored
   assign take           = rx_valid & armed;
   assign is_rt          = (rx_data >= 8'hF8);
   assign is_chan_status = rx_data[7] & (rx_data < 8'hF0);
   assign is_data        = ~rx_data[7];

   always_ff @(posedge data_clk or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         state        <= IDLE;
         exp_len      <= 2'd0;
         armed        <= 1'b0;
         byteready    <= 1'b0;
         cur_status   <= 8'h00;
         midibyte_nr  <= 8'h00;
         midi_in_data <= 8'h00;
         sysex_active <= 1'b0;
         rt_strobe    <= 1'b0;
         rt_data      <= 8'h00;
         drop_cnt     <= 8'h00;
      end else begin
         armed     <= 1'b1;
         byteready <= 1'b0;
         rt_strobe <= 1'b0;
         // The F7 pulse has already gone out; close the sysex frame now, while still taking a new byte
         if (state == SYX_END) begin
            cur_status   <= 8'h00;
            sysex_active <= 1'b0;
            state        <= IDLE;
         end
         if (take) begin
            if (is_rt) begin
               if (RT_PASS != 0) begin
                  rt_strobe <= 1'b1;
                  rt_data   <= rx_data;
               end
            end else if (is_chan_status) begin
               cur_status   <= rx_data;
               midibyte_nr  <= 8'h00;
               midi_in_data <= rx_data;
               byteready    <= 1'b1;
               sysex_active <= 1'b0;
               exp_len      <= (rx_data[7:4] == 4'hC || rx_data[7:4] == 4'hD) ? 2'd1 : 2'd2;
               state        <= CHAN;
            end else if (rx_data == 8'hF0) begin
               cur_status   <= 8'hF0;
               midibyte_nr  <= 8'h00;
               midi_in_data <= 8'hF0;
               byteready    <= 1'b1;
               sysex_active <= 1'b1;
               state        <= SYSEX;
            end else if (rx_data == 8'hF7 && state == SYSEX) begin
               midibyte_nr  <= sat_inc(midibyte_nr);
               midi_in_data <= 8'hF7;
               byteready    <= 1'b1;
               state        <= SYX_END;
            end else if (!is_data) begin
               cur_status   <= 8'h00;
               sysex_active <= 1'b0;
               drop_cnt     <= sat_inc(drop_cnt);
               state        <= IDLE;
            end else begin
               case (state)
                  CHAN: begin
                     midibyte_nr  <= (midibyte_nr == {6'd0, exp_len}) ? 8'd1 : midibyte_nr + 8'd1;
                     midi_in_data <= rx_data;
                     byteready    <= 1'b1;
                  end
                  SYSEX: begin
                     midibyte_nr  <= sat_inc(midibyte_nr);
                     midi_in_data <= rx_data;
                     byteready    <= 1'b1;
                  end
                  default: drop_cnt <= sat_inc(drop_cnt);
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_midi_byte_parser.sv
// Bench for midi_byte_parser: directed literal cases plus randomized bytes checked every cycle
// against a message-level model of the MIDI parsing rules.
module tb_midi_byte_parser;

   logic       data_clk;
   logic       reset_reg_N;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       byteready;
   logic [7:0] cur_status;
   logic [7:0] midibyte_nr;
   logic [7:0] midi_in_data;
   logic       sysex_active;
   logic       rt_strobe;
   logic [7:0] rt_data;
   logic [7:0] drop_cnt;

   int total = 0;
   int bad   = 0;

   int m_status, m_nr, m_data, m_drop, m_rtdata;
   bit m_sysex, m_br, m_rt, m_end, m_ignore;

   midi_byte_parser #(.RT_PASS(1)) dut (
      .data_clk(data_clk),
      .reset_reg_N(reset_reg_N),
      .rx_valid(rx_valid),
      .rx_data(rx_data),
      .byteready(byteready),
      .cur_status(cur_status),
      .midibyte_nr(midibyte_nr),
      .midi_in_data(midi_in_data),
      .sysex_active(sysex_active),
      .rt_strobe(rt_strobe),
      .rt_data(rt_data),
      .drop_cnt(drop_cnt)
   );

   initial data_clk = 1'b0;
   always #5 data_clk = ~data_clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int msgLen(input int status);
      return (status >= 8'hC0 && status <= 8'hDF) ? 1 : 2;
   endfunction

   function automatic int satInc(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   // Model: what the outputs must read after the next clock edge, given this byte
   task automatic applyStimulus(input bit v, input logic [7:0] b);
      int bi;
      bit take;
      @(negedge data_clk);
      rx_valid = v;
      rx_data  = b;
      bi   = int'(b);
      take = v && !m_ignore;
      m_ignore = 1'b0;
      m_br = 1'b0;
      m_rt = 1'b0;
      if (m_end) begin
         m_status = 0;
         m_sysex  = 1'b0;
         m_end    = 1'b0;
      end
      if (take) begin
         if (bi >= 8'hF8) begin
            m_rt     = 1'b1;
            m_rtdata = bi;
         end else if (bi >= 8'h80 && bi <= 8'hEF) begin
            m_status = bi; m_nr = 0; m_data = bi; m_br = 1'b1; m_sysex = 1'b0;
         end else if (bi == 8'hF0) begin
            m_status = bi; m_nr = 0; m_data = bi; m_br = 1'b1; m_sysex = 1'b1;
         end else if (bi == 8'hF7 && m_sysex) begin
            m_nr = satInc(m_nr); m_data = bi; m_br = 1'b1; m_end = 1'b1;
         end else if (bi >= 8'hF1) begin
            m_status = 0; m_sysex = 1'b0; m_drop = satInc(m_drop);
         end else if (m_status == 0) begin
            m_drop = satInc(m_drop);
         end else if (m_sysex) begin
            m_nr = satInc(m_nr); m_data = bi; m_br = 1'b1;
         end else begin
            m_nr = (m_nr == msgLen(m_status)) ? 1 : m_nr + 1;
            m_data = bi; m_br = 1'b1;
         end
      end
      @(posedge data_clk);
      #3;
   endtask

   task automatic doReset();
      @(negedge data_clk);
      reset_reg_N = 1'b0;
      rx_valid    = 1'b0;
      rx_data     = 8'h00;
      m_status = 0; m_nr = 0; m_data = 0; m_drop = 0; m_rtdata = 0;
      m_sysex = 1'b0; m_br = 1'b0; m_rt = 1'b0; m_end = 1'b0;
      #1;
      checkOutput("rst_byteready", byteready, 0);
      checkOutput("rst_status", cur_status, 0);
      checkOutput("rst_nr", midibyte_nr, 0);
      checkOutput("rst_sysex", sysex_active, 0);
      checkOutput("rst_drop", drop_cnt, 0);
      repeat (2) @(posedge data_clk);
      #4;
      reset_reg_N = 1'b1;
      m_ignore    = 1'b1;
   endtask

   task automatic litByte(input logic [7:0] b, input int br, input int st, input int nr, input int d);
      applyStimulus(1'b1, b);
      checkOutput("lit_byteready", byteready, br);
      checkOutput("lit_status", cur_status, st);
      checkOutput("lit_nr", midibyte_nr, nr);
      if (br != 0) checkOutput("lit_data", midi_in_data, d);
   endtask

   function automatic logic [7:0] randByte();
      int r;
      r = $urandom_range(99);
      if (r < 50)      return 8'($urandom_range(127));
      else if (r < 68) return 8'($urandom_range(8'hEF, 8'h80));
      else if (r < 76) return 8'hF0;
      else if (r < 84) return 8'hF7;
      else if (r < 88) return 8'($urandom_range(8'hF6, 8'hF1));
      else             return 8'($urandom_range(8'hFF, 8'hF8));
   endfunction

   // Every cycle, the registered outputs must equal the model's view
   always @(posedge data_clk) begin
      #2;
      checkOutput("byteready", byteready, m_br);
      checkOutput("cur_status", cur_status, m_status);
      checkOutput("midibyte_nr", midibyte_nr, m_nr);
      checkOutput("midi_in_data", midi_in_data, m_data);
      checkOutput("sysex_active", sysex_active, m_sysex);
      checkOutput("rt_strobe", rt_strobe, m_rt);
      checkOutput("rt_data", rt_data, m_rtdata);
      checkOutput("drop_cnt", drop_cnt, m_drop);
   end

   initial begin
      reset_reg_N = 1'b0;
      rx_valid    = 1'b0;
      rx_data     = 8'h00;
      doReset();
      applyStimulus(1'b1, 8'h90);
      checkOutput("release_edge_ignored", byteready, 0);
      applyStimulus(1'b0, 8'h00);

      litByte(8'h90, 1, 8'h90, 0, 8'h90);
      litByte(8'h3C, 1, 8'h90, 1, 8'h3C);
      litByte(8'h64, 1, 8'h90, 2, 8'h64);
      litByte(8'h3C, 1, 8'h90, 1, 8'h3C);
      litByte(8'h00, 1, 8'h90, 2, 8'h00);

      litByte(8'hC5, 1, 8'hC5, 0, 8'hC5);
      litByte(8'h07, 1, 8'hC5, 1, 8'h07);
      litByte(8'h09, 1, 8'hC5, 1, 8'h09);

      litByte(8'h90, 1, 8'h90, 0, 8'h90);
      litByte(8'h3C, 1, 8'h90, 1, 8'h3C);
      litByte(8'hF8, 0, 8'h90, 1, 0);
      checkOutput("lit_rt_strobe", rt_strobe, 1);
      checkOutput("lit_rt_data", rt_data, 8'hF8);
      litByte(8'h64, 1, 8'h90, 2, 8'h64);

      litByte(8'hF0, 1, 8'hF0, 0, 8'hF0);
      litByte(8'h7D, 1, 8'hF0, 1, 8'h7D);
      litByte(8'h01, 1, 8'hF0, 2, 8'h01);
      litByte(8'hF7, 1, 8'hF0, 3, 8'hF7);
      checkOutput("lit_sysex_at_f7", sysex_active, 1);
      applyStimulus(1'b0, 8'h00);
      checkOutput("lit_sysex_after_f7", sysex_active, 0);
      checkOutput("lit_status_after_f7", cur_status, 0);

      doReset();
      applyStimulus(1'b0, 8'h00);
      litByte(8'h40, 0, 0, 0, 0);
      litByte(8'hF3, 0, 0, 0, 0);
      checkOutput("lit_drop_2", drop_cnt, 2);
      for (int i = 0; i < 300; i++) applyStimulus(1'b1, 8'h11);
      checkOutput("lit_drop_sat", drop_cnt, 8'hFF);

      doReset();
      applyStimulus(1'b0, 8'h00);
      litByte(8'h90, 1, 8'h90, 0, 8'h90);
      litByte(8'h3C, 1, 8'h90, 1, 8'h3C);
      doReset();
      applyStimulus(1'b0, 8'h00);
      litByte(8'h64, 0, 0, 0, 0);
      checkOutput("lit_drop_after_reset", drop_cnt, 1);

      litByte(8'hF0, 1, 8'hF0, 0, 8'hF0);
      for (int i = 0; i < 260; i++) applyStimulus(1'b1, 8'h05);
      checkOutput("lit_sysex_nr_sat", midibyte_nr, 8'hFF);
      litByte(8'hF7, 1, 8'hF0, 8'hFF, 8'hF7);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(399) == 0) doReset();
         applyStimulus(($urandom_range(9) < 7), randByte());
      end
      applyStimulus(1'b0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/midi_byte_parser.md
MIDI_BYTE_PARSER -- requirements
Module: midi_byte_parser

Interface
REQ-001 Parameter: RT_PASS, default 1, meaning 1 = drive realtime bytes onto rt_strobe/rt_data, 0 = discard them silently.
REQ-002 data_clk  input  1  system clock; all state changes on posedge.
REQ-003 reset_reg_N  input  1  reset, asynchronous, active-low.
REQ-004 rx_valid  input  1  one-cycle strobe: rx_data holds a received MIDI byte.
REQ-005 rx_data  input  8  received MIDI byte.
REQ-006 byteready  output  1  one-cycle pulse: cur_status, midibyte_nr and midi_in_data describe one accepted byte.
REQ-007 cur_status  output  8  active status byte (running status); 8'h00 = none.
REQ-008 midibyte_nr  output  8  position of the byte within the message: 0 = status, 1..n = data.
REQ-009 midi_in_data  output  8  accepted byte value.
REQ-010 sysex_active  output  1  high from F0 acceptance until F7 or abort.
REQ-011 rt_strobe  output  1  one-cycle pulse for a realtime byte (F8-FF) when RT_PASS=1.
REQ-012 rt_data  output  8  realtime byte value, valid with rt_strobe.
REQ-013 drop_cnt  output  8  saturating count of discarded bytes.

Function
REQ-014 The block SHALL register all outputs; byteready/rt_strobe SHALL assert exactly 1 cycle after the rx_valid cycle and SHALL accept rx_valid on consecutive cycles without loss.
REQ-015 Byte class F8-FF SHALL NOT alter cur_status, midibyte_nr, the expected length or sysex_active, even mid-message or mid-sysex; it SHALL pulse rt_strobe (RT_PASS=1) and never byteready.
REQ-016 Status 80-EF SHALL set cur_status=byte, midibyte_nr=0, midi_in_data=byte, pulse byteready, clear sysex_active.
REQ-017 Expected data length SHALL be 2 for 8x/9x/Ax/Bx/Ex and 1 for Cx/Dx.
REQ-018 Data byte (00-7F) with channel status SHALL increment midibyte_nr and pulse byteready; a data byte arriving after the message is complete (midibyte_nr == length) SHALL restart at midibyte_nr=1 (running status).
REQ-019 F0 SHALL set cur_status=F0, midibyte_nr=0, sysex_active=1 and pulse byteready.
REQ-020 Data bytes during sysex SHALL pulse byteready with midibyte_nr incrementing and saturating at 8'hFF (no wrap).
REQ-021 F7 during sysex SHALL pulse byteready with midi_in_data=F7, midibyte_nr incremented (saturating), then clear sysex_active and set cur_status=00 on the following cycle.
REQ-022 Status 80-EF during sysex SHALL abort the sysex (sysex_active=0) and proceed per REQ-016; no F7 is synthesised.
REQ-023 F1-F6, and F7 outside sysex, SHALL set cur_status=00 and sysex_active=0, emit no byteready, and increment drop_cnt.
REQ-024 A data byte while cur_status=00 SHALL be discarded, emit no byteready, and increment drop_cnt.
REQ-025 drop_cnt SHALL saturate at 8'hFF.
REQ-026 State machine states: IDLE (no status), CHAN (channel message), SYSEX, SYX_END (single cycle after F7, returns to IDLE); transitions SHALL follow REQ-016..024.

Reset
REQ-027 Asserting reset_reg_N low SHALL immediately force byteready=0, rt_strobe=0, cur_status=00, midibyte_nr=00, midi_in_data=00, rt_data=00, sysex_active=0, drop_cnt=00 and state IDLE, including mid-message and mid-sysex.
REQ-028 An rx_valid coinciding with the reset release edge SHALL be ignored.

Verification
REQ-029 Input 90 3C 64 3C 00 -> five byteready pulses with (cur_status, midibyte_nr, data) = (90,0,90), (90,1,3C), (90,2,64), (90,1,3C), (90,2,00).
REQ-030 Input C5 07 09 -> (C5,0,C5), (C5,1,07), (C5,1,09).
REQ-031 Input 90 3C F8 64 with RT_PASS=1 -> rt_strobe with rt_data=F8 between the pulses; 64 is reported as (90,2,64).
REQ-032 Input F0 7D 01 F7 -> midibyte_nr 0,1,2,3; sysex_active=1 until the cycle after F7; then cur_status=00.
REQ-033 After reset, input 40 then F3 -> no byteready; drop_cnt=2; 300 stray data bytes -> drop_cnt=FF.
REQ-034 Input 90 3C with reset pulsed low before 64, then input 64 -> no byteready after reset; drop_cnt=1.
